ffntt_stream_tx: RTL and testbench

AXI-Stream master transmitter that feeds the fiFFNTT accelerator's ss_* input port. It reads a contiguous block of 32-bit words from a local single-port SRAM and streams them out. This covers constant tables (FFT re/im quads, packed NTT/iNTT pairs) and IOP data. tlast marks the final word. Used by the middleware-side test harness and by the later SoC wrapper to load the accelerator without CPU word-by-word writes.

---
 rtl/ffntt_pkg.sv | 27 ++
 rtl/ffntt_stream_tx_fifo.sv | 40 ++++
 rtl/ffntt_stream_tx.sv | 118 +++++++++++
 tb/tb_ffntt_stream_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffntt_pkg.sv
// Shared constants and types for the fiFFNTT stream loader.
// Width defaults, TX FSM encoding and constant-table layout helpers.
package ffntt_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  localparam int FFT_BEATS = 4;
  localparam int NTT_LSB   = 0;
  localparam int INTT_LSB  = 16;
  localparam int HALF_W    = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_RUN   = 2'd1,
    TX_FLUSH = 2'd2
  } tx_state_t;

  function automatic logic [DATA_W-1:0] ntt_pack(
    input logic [HALF_W-1:0] ntt,
    input logic [HALF_W-1:0] intt
  );
    return {intt, ntt};
  endfunction

endpackage

// File: rtl/ffntt_stream_tx_fifo.sv
// Two-entry skid FIFO between the SRAM return path and the stream port.
// Head only moves on pop, so stream data holds steady while stalled.
module ffntt_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ffntt_stream_tx.sv
// SRAM-to-AXI-Stream block transmitter feeding the fiFFNTT ss_* port.
// Reads length words from base upward (address wraps) and marks the last beat.
module ffntt_stream_tx
  import ffntt_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_W,
  parameter int pDATA_WIDTH = DATA_W,
  parameter int pLEN_WIDTH  = LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [pADDR_WIDTH-1:0] base_addr,
  input  logic [pLEN_WIDTH-1:0]  length,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_en,
  output logic [pADDR_WIDTH-1:0] sram_addr,
  input  logic [pDATA_WIDTH-1:0] sram_rdata,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready
);

  tx_state_t state;
  tx_state_t state_nx;

  logic [pADDR_WIDTH-1:0] base_q;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [pLEN_WIDTH-1:0]  reads_q;
  logic [pLEN_WIDTH-1:0]  sent_q;
  logic                   inflight_q;

  logic [1:0]             fifo_cnt;
  logic [pDATA_WIDTH-1:0] fifo_head;
  logic [2:0]             pending;
  logic                   accept;
  logic                   credit_ok;
  logic                   more_reads;
  logic                   hs;

  assign accept = (state == TX_IDLE) & start;
  assign hs     = m_tvalid & m_tready;

  // Slots still owed after this cycle's pop; counting the pop keeps 1 beat/cycle.
  assign pending    = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, hs};
  assign credit_ok  = pending < 3'd2;
  assign more_reads = reads_q < len_q;

  assign sram_en   = (state == TX_RUN) & more_reads & credit_ok;
  assign sram_addr = base_q + pADDR_WIDTH'(reads_q);

  assign m_tvalid = fifo_cnt != 2'd0;
  assign m_tdata  = fifo_head;
  assign m_tlast  = m_tvalid & (sent_q == len_q - 1'b1);

  assign busy = state == TX_RUN;
  assign done = state == TX_FLUSH;

  always_comb begin
    state_nx = state;
    unique case (state)
      TX_IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? TX_FLUSH : TX_RUN;
        end
      end
      TX_RUN: begin
        if (hs & m_tlast) begin
          state_nx = TX_FLUSH;
        end
      end
      TX_FLUSH: state_nx = TX_IDLE;
      default:  state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      reads_q    <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state      <= state_nx;
      inflight_q <= sram_en;
      if (accept) begin
        base_q  <= base_addr;
        len_q   <= length;
        reads_q <= '0;
        sent_q  <= '0;
      end else begin
        if (sram_en) begin
          reads_q <= reads_q + 1'b1;
        end
        if (hs) begin
          sent_q <= sent_q + 1'b1;
        end
      end
    end
  end

  ffntt_skid_fifo #(
    .W (pDATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (hs),
    .din   (sram_rdata),
    .count (fifo_cnt),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_ffntt_stream_tx.sv
// Directed bench for ffntt_stream_tx with a transfer-level reference model.
// Model tracks words requested/returned/sent and checks every negedge.
module tb_ffntt_stream_tx;
  import ffntt_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy;
  logic              done;
  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready = 1'b0;

  always #5 clk = ~clk;

  ffntt_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready)
  );

  logic [DATA_W-1:0] mem [4096];

  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Written by the stimulus process only
  int                xfer_id = 0;
  int                zero_id = 0;
  int                acc_cyc = 0;
  logic [ADDR_W-1:0] exp_base = '0;
  logic [LEN_W-1:0]  exp_len = '0;

  // Written by the monitor only
  int                cyc = 0;
  int                issued = 0;
  int                popped = 0;
  int                i1 = 0;
  int                i2 = 0;
  int                seen_id = 0;
  int                seen_zero = 0;
  int                done_cnt = 0;
  bit                active = 0;
  bit                done_pend = 0;
  logic [DATA_W-1:0] beat_q[$];
  bit                last_q[$];
  int                beat_cyc_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                done_cyc_q[$];

  initial begin
    bit                act0;
    bit                v_exp;
    bit                en_exp;
    bit                nxt_done;
    logic [ADDR_W-1:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0; done_pend = 0;
        issued = 0; popped = 0; i1 = 0; i2 = 0;
        seen_id = xfer_id; seen_zero = zero_id;
      end else begin
        if (xfer_id != seen_id) begin
          seen_id = xfer_id; active = 1;
          issued = 0; popped = 0; i1 = 0; i2 = 0;
        end
        if (zero_id != seen_zero) begin
          seen_zero = zero_id; done_pend = 1;
        end
        chk("done", done, done_pend);
        if (done) begin
          done_cnt++;
          done_cyc_q.push_back(cyc);
        end
        chk("busy", busy, active);
        act0 = active;
        nxt_done = 0;
        v_exp = active && (i2 > popped);
        chk("tvalid", m_tvalid, v_exp);
        if (v_exp) begin
          ea = exp_base + ADDR_W'(popped);
          chk("tdata", m_tdata, mem[ea]);
          chk("tlast", m_tlast, popped == int'(exp_len) - 1);
          if (m_tready) begin
            beat_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
            beat_cyc_q.push_back(cyc);
            popped++;
            if (popped == int'(exp_len)) begin
              active = 0;
              nxt_done = 1;
            end
          end
        end
        en_exp = act0 && (issued < int'(exp_len)) && (issued - popped < 2);
        chk("sram_en", sram_en, en_exp);
        if (sram_en) begin
          addr_q.push_back(sram_addr);
          ea = exp_base + ADDR_W'(issued);
          chk("sram_addr", sram_addr, ea);
          issued++;
        end
        done_pend = nxt_done;
        i2 = i1;
        i1 = issued;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] pat = 16'b0110_1001_1100_1001;

  task automatic go(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    acc_cyc = cyc;
    exp_base = b;
    exp_len = l;
    if (l != '0) xfer_id++;
    else zero_id++;
  endtask

  task automatic wait_done(input int bound, input bit bp);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < bound) begin
      @(posedge clk); #1;
      if (bp) m_tready = pat[k % 16];
      k++;
    end
    m_tready = 1'b1;
    chk("done_seen", done_cnt - d0, 1);
  endtask

  initial begin
    int n0;
    int a0;
    int k;
    int d;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", sram_en, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);

    // Basic 4-word transfer
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + i;
    n0 = beat_q.size();
    go(12'h010, 16'd4);
    wait_done(40, 0);
    chk("basic_n", beat_q.size() - n0, 4);
    chk("basic_b0", beat_q[n0], 32'h0000_00A0);
    chk("basic_b1", beat_q[n0+1], 32'h0000_00A1);
    chk("basic_b2", beat_q[n0+2], 32'h0000_00A2);
    chk("basic_b3", beat_q[n0+3], 32'h0000_00A3);
    chk("basic_last", {last_q[n0], last_q[n0+1], last_q[n0+2], last_q[n0+3]},
        4'b0001);
    chk("basic_first_lat", beat_cyc_q[n0] - acc_cyc, 3);
    chk("basic_back2back", beat_cyc_q[n0+3] - beat_cyc_q[n0], 3);
    chk("basic_done_lat", done_cyc_q[done_cyc_q.size()-1] - acc_cyc, 7);

    // Backpressure
    for (int i = 0; i < 8; i++) mem[12'h400 + i] = 32'hB0 + i;
    n0 = beat_q.size();
    go(12'h400, 16'd8);
    wait_done(200, 1);
    chk("bp_n", beat_q.size() - n0, 8);
    chk("bp_b0", beat_q[n0], 32'h0000_00B0);
    chk("bp_b5", beat_q[n0+5], 32'h0000_00B5);
    chk("bp_b7", beat_q[n0+7], 32'h0000_00B7);
    chk("bp_last", last_q[n0+7], 1);

    // Address wrap
    mem[12'hFFE] = 32'h1111_0FFE;
    mem[12'hFFF] = 32'h1111_0FFF;
    mem[12'h000] = 32'h1111_0000;
    mem[12'h001] = 32'h1111_0001;
    n0 = beat_q.size();
    a0 = addr_q.size();
    go(12'hFFE, 16'd4);
    wait_done(40, 0);
    chk("wrap_a0", addr_q[a0], 12'hFFE);
    chk("wrap_a1", addr_q[a0+1], 12'hFFF);
    chk("wrap_a2", addr_q[a0+2], 12'h000);
    chk("wrap_a3", addr_q[a0+3], 12'h001);
    chk("wrap_b1", beat_q[n0+1], 32'h1111_0FFF);
    chk("wrap_b2", beat_q[n0+2], 32'h1111_0000);

    // Zero length
    n0 = beat_q.size();
    a0 = addr_q.size();
    go(12'h300, 16'd0);
    wait_done(10, 0);
    chk("zero_beats", beat_q.size() - n0, 0);
    chk("zero_reads", addr_q.size() - a0, 0);
    chk("zero_done_lat", done_cyc_q[done_cyc_q.size()-1] - acc_cyc, 1);

    // Start while running is ignored
    for (int i = 0; i < 4; i++) mem[12'h020 + i] = 32'hE0 + i;
    n0 = beat_q.size();
    d = done_cnt;
    go(12'h020, 16'd4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h040; length = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, 0);
    repeat (4) @(posedge clk);
    chk("ign_n", beat_q.size() - n0, 4);
    chk("ign_b0", beat_q[n0], 32'h0000_00E0);
    chk("ign_b3", beat_q[n0+3], 32'h0000_00E3);
    chk("ign_dones", done_cnt - d, 1);

    // Reset mid-transfer
    for (int i = 0; i < 8; i++) mem[12'h100 + i] = 32'hC0 + i;
    n0 = beat_q.size();
    go(12'h100, 16'd8);
    k = 0;
    while (beat_q.size() < n0 + 2 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_two_beats", beat_q.size() - n0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d = done_cnt;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_en", sram_en, 0);
    chk("abort_addr", sram_addr, 0);
    chk("abort_tvalid", m_tvalid, 0);
    chk("abort_tdata", m_tdata, 0);
    chk("abort_tlast", m_tlast, 0);
    repeat (5) @(posedge clk);
    chk("abort_no_done", done_cnt - d, 0);
    n0 = beat_q.size();
    go(12'h100, 16'd8);
    wait_done(60, 0);
    chk("fresh_n", beat_q.size() - n0, 8);
    chk("fresh_b0", beat_q[n0], 32'h0000_00C0);
    chk("fresh_b7", beat_q[n0+7], 32'h0000_00C7);

    // Single word
    mem[12'h200] = 32'hDEAD_BEEF;
    n0 = beat_q.size();
    go(12'h200, 16'd1);
    wait_done(20, 0);
    chk("single_n", beat_q.size() - n0, 1);
    chk("single_data", beat_q[n0], 32'hDEAD_BEEF);
    chk("single_last", last_q[n0], 1);
    chk("single_lat", beat_cyc_q[n0] - acc_cyc, 3);
    chk("single_done_lat", done_cyc_q[done_cyc_q.size()-1] - acc_cyc, 4);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
